// File: rtl/pcie_arb_pkg.sv
// Shared definitions for the PCIe / GPU memory-port arbiter: FSM encoding,
// register-window default addresses and error-flag bit positions.
package pcie_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } arb_state_t;

    localparam logic [15:0] CTRL_ADDR_DEF = 16'hFFF0;
    localparam logic [15:0] STAT_ADDR_DEF = 16'hFFF4;

    localparam int ERR_WR_OVF = 0;
    localparam int ERR_RD_OVR = 1;

endpackage

// File: rtl/arb_wr_fifo.sv
// Posted-write FIFO. Entries are held in registers so every queued address
// can be compared against a pending read in parallel.
module arb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic                      tlp_clk,
    input  logic                      w_rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [AW-1:0]             push_addr,
    input  logic [DW-1:0]             push_data,
    output logic                      full,
    output logic                      empty,
    output logic [AW-1:0]             head_addr,
    output logic [DW-1:0]             head_data,
    output logic [DEPTH-1:0]          entry_valid,
    output logic [DEPTH-1:0][AW-1:0]  entry_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic          do_push, do_pop;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    always_ff @(posedge tlp_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge tlp_clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset          = PW'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = ({1'b0, offset} < count_reg);
            assign entry_addr[gi]  = addr_mem[gi];
        end
    endgenerate

endmodule

// File: rtl/pcie_mem_arbiter.sv
// Arbitrates the GPU memory port between buffered PCIe writes and single
// outstanding reads, and hosts the GPU start/status register window.
module pcie_mem_arbiter
    import pcie_arb_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter int                WF_DEPTH   = 4,
    parameter int                STARVE_MAX = 4,
    parameter logic [ADDR_W-1:0] CTRL_ADDR  = CTRL_ADDR_DEF,
    parameter logic [ADDR_W-1:0] STAT_ADDR  = STAT_ADDR_DEF
) (
    input  logic              tlp_clk,
    input  logic              w_rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_wr_req,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              gpu_start,
    input  logic              gpu_done,
    output logic              gpu_busy,
    output logic [1:0]        err_flags
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t                     state_reg, state_next;
    logic                           fifo_full, fifo_empty, fifo_pop;
    logic [ADDR_W-1:0]              head_addr;
    logic [DATA_W-1:0]              head_data;
    logic [WF_DEPTH-1:0]            entry_valid, hit_vec;
    logic [WF_DEPTH-1:0][ADDR_W-1:0] entry_addr;

    logic                rd_pend_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [SW-1:0]       starve_cnt_reg;
    logic                mem_wr_req_reg, mem_rd_req_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic                rd_ready_reg;
    logic [DATA_W-1:0]   rd_data_reg;
    logic                gpu_start_reg, gpu_busy_reg, done_sticky_reg;
    logic                sync1_reg, sync2_reg, sync3_reg;
    logic [1:0]          err_reg;

    logic grant_wr, grant_rd, rd_done, ctrl_start, hazard;
    logic head_is_ctrl, head_is_reg, rd_is_stat, done_rise;

    arb_wr_fifo #(.DEPTH(WF_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_wr_fifo (
        .tlp_clk     (tlp_clk),
        .w_rst_n     (w_rst_n),
        .push        (wr_req),
        .pop         (fifo_pop),
        .push_addr   (wr_addr),
        .push_data   (wr_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // A read must not overtake any queued write to the same address.
    genvar gi;
    generate
        for (gi = 0; gi < WF_DEPTH; gi++) begin : g_hazard
            assign hit_vec[gi] = entry_valid[gi] && (entry_addr[gi] == rd_addr_reg);
        end
    endgenerate

    assign hazard       = |hit_vec;
    assign head_is_ctrl = (head_addr == CTRL_ADDR);
    assign head_is_reg  = head_is_ctrl || (head_addr == STAT_ADDR);
    assign rd_is_stat   = (rd_addr_reg == STAT_ADDR);
    assign done_rise    = sync2_reg && !sync3_reg;

    always_comb begin
        state_next = state_reg;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        fifo_pop   = 1'b0;
        rd_done    = 1'b0;
        ctrl_start = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && (!rd_pend_reg || fifo_full ||
                        starve_cnt_reg == SW'(STARVE_MAX) || hazard)) begin
                    grant_wr   = 1'b1;
                    state_next = ST_WR;
                end else if (rd_pend_reg) begin
                    grant_rd   = 1'b1;
                    state_next = ST_RD;
                end
            end
            ST_WR: begin
                if (head_is_reg) begin
                    fifo_pop   = 1'b1;
                    ctrl_start = head_is_ctrl && head_data[0] && !gpu_busy_reg;
                    state_next = ST_IDLE;
                end else if (mem_ready) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_RD: begin
                if (rd_is_stat || mem_ready) begin
                    rd_done    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge tlp_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_reg       <= ST_IDLE;
            rd_pend_reg     <= 1'b0;
            rd_addr_reg     <= '0;
            starve_cnt_reg  <= '0;
            mem_wr_req_reg  <= 1'b0;
            mem_rd_req_reg  <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            rd_ready_reg    <= 1'b0;
            rd_data_reg     <= '0;
            gpu_start_reg   <= 1'b0;
            gpu_busy_reg    <= 1'b0;
            done_sticky_reg <= 1'b0;
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            sync3_reg       <= 1'b0;
            err_reg         <= '0;
        end else begin
            state_reg <= state_next;

            // Strobes are raised on the grant edge so they appear with the new state.
            if (grant_wr) begin
                mem_wr_req_reg <= !head_is_reg;
                mem_addr_reg   <= head_addr;
                mem_wdata_reg  <= head_data;
            end else if (fifo_pop) begin
                mem_wr_req_reg <= 1'b0;
            end
            if (grant_rd) begin
                mem_rd_req_reg <= !rd_is_stat;
                mem_addr_reg   <= rd_addr_reg;
            end else if (rd_done) begin
                mem_rd_req_reg <= 1'b0;
            end

            rd_ready_reg <= rd_done;
            if (rd_done)
                rd_data_reg <= rd_is_stat ? DATA_W'({done_sticky_reg, gpu_busy_reg}) : mem_rdata;

            // The slot frees on the completion cycle, so a request arriving then is kept.
            if (rd_req && (!rd_pend_reg || rd_done)) begin
                rd_pend_reg <= 1'b1;
                rd_addr_reg <= rd_addr;
            end else if (rd_done) begin
                rd_pend_reg <= 1'b0;
            end

            if (grant_wr)
                starve_cnt_reg <= '0;
            else if (grant_rd && !fifo_empty)
                starve_cnt_reg <= starve_cnt_reg + SW'(1);

            if (wr_req && fifo_full)               err_reg[ERR_WR_OVF] <= 1'b1;
            if (rd_req && rd_pend_reg && !rd_done) err_reg[ERR_RD_OVR] <= 1'b1;

            sync1_reg     <= gpu_done;
            sync2_reg     <= sync1_reg;
            sync3_reg     <= sync2_reg;
            gpu_start_reg <= ctrl_start;
            if (ctrl_start) begin
                gpu_busy_reg    <= 1'b1;
                done_sticky_reg <= 1'b0;
            end else if (done_rise) begin
                gpu_busy_reg    <= 1'b0;
                done_sticky_reg <= 1'b1;
            end
        end
    end

    assign wr_ready   = !fifo_full;
    assign rd_ready   = rd_ready_reg;
    assign rd_data    = rd_data_reg;
    assign mem_wr_req = mem_wr_req_reg;
    assign mem_rd_req = mem_rd_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign gpu_start  = gpu_start_reg;
    assign gpu_busy   = gpu_busy_reg;
    assign err_flags  = err_reg;

endmodule

// File: tb/tb_pcie_mem_arbiter.sv
// Directed bench for pcie_mem_arbiter: scoreboard queues hold the expected
// memory transactions and read returns; monitors pop and compare them.
module tb_pcie_mem_arbiter;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } mem_op_t;

    logic        tlp_clk = 1'b0, w_rst_n = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0, mem_ready = 1'b0, gpu_done = 1'b0;
    logic [15:0] wr_addr = '0, rd_addr = '0;
    logic [31:0] wr_data = '0, mem_rdata = '0;
    logic        wr_ready, rd_ready, mem_wr_req, mem_rd_req, gpu_start, gpu_busy;
    logic [31:0] rd_data, mem_wdata;
    logic [15:0] mem_addr;
    logic [1:0]  err_flags;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, mem_delay = 0, wait_cnt = 0;
    int n_rd_done = 0, rd_at_last_wr = 0, rd_mem_cyc = 0, rd_ready_cyc = 0;
    int n_gpu_start = 0, rd_issue_cyc = 0, base_rd = 0;
    logic mem_stall = 1'b0, got;
    mem_op_t     exp_mem[$];
    logic [31:0] exp_rd[$];

    pcie_mem_arbiter dut (
        .tlp_clk(tlp_clk), .w_rst_n(w_rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
        .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .gpu_start(gpu_start), .gpu_done(gpu_done), .gpu_busy(gpu_busy),
        .err_flags(err_flags)
    );

    always #5 tlp_clk = ~tlp_clk;
    always @(posedge tlp_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic mem_op_t mop(input logic w, input logic [15:0] a, input logic [31:0] d);
        mop.wr   = w;
        mop.addr = a;
        mop.data = d;
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge tlp_clk);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        @(negedge tlp_clk);
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a);
        @(negedge tlp_clk);
        rd_req = 1'b1; rd_addr = a; rd_issue_cyc = cyc;
        @(negedge tlp_clk);
        rd_req = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge tlp_clk);
            if (exp_mem.size() == 0 && exp_rd.size() == 0) break;
        end
        repeat (4) @(negedge tlp_clk);
        check(tag, 64'(exp_mem.size() + exp_rd.size()), 64'd0);
    endtask

    // Memory model: answers each strobe after mem_delay cycles unless stalled.
    initial begin
        mem_op_t op;
        forever begin
            @(negedge tlp_clk);
            mem_ready = 1'b0;
            if (w_rst_n && (mem_wr_req || mem_rd_req) && !mem_stall) begin
                if (wait_cnt < mem_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt  = 0;
                    mem_ready = 1'b1;
                    check("mem_op_expected", 64'(exp_mem.size() != 0), 64'd1);
                    if (exp_mem.size() != 0) begin
                        op = exp_mem.pop_front();
                        check("mem_op", 64'({mem_wr_req, mem_rd_req, mem_addr, mem_wr_req ? mem_wdata : 32'h0}),
                              64'({op.wr, !op.wr, op.addr, op.wr ? op.data : 32'h0}));
                        mem_rdata = op.data;
                    end else begin
                        mem_rdata = 32'hDEAD_BEEF;
                    end
                    if (mem_rd_req) begin
                        n_rd_done++;
                        rd_mem_cyc = cyc;
                    end else begin
                        rd_at_last_wr = n_rd_done;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge tlp_clk);
            if (rd_ready === 1'b1) begin
                rd_ready_cyc = cyc;
                check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
                if (exp_rd.size() != 0) check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
            end
            if (gpu_start === 1'b1) begin
                n_gpu_start++;
                check("busy_with_start", 64'(gpu_busy), 64'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge tlp_clk);
        #1;
        check("rst_ctl", 64'({mem_wr_req, mem_rd_req, rd_ready, gpu_start, gpu_busy, err_flags, wr_ready}),
              64'b0000_0001);
        check("rst_data", 64'({mem_addr, mem_wdata}), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge tlp_clk);
        w_rst_n = 1'b1;

        // Single write with one-cycle memory latency
        mem_delay = 1;
        exp_mem.push_back(mop(1'b1, 16'h0010, 32'hCAFE_F00D));
        do_write(16'h0010, 32'hCAFE_F00D);
        #1 check("wr1_ready", 64'(wr_ready), 64'd1);
        drain("wr1_drain");
        check("wr1_ready_after", 64'(wr_ready), 64'd1);
        mem_delay = 0;

        // Read latency T -> T+2 strobe -> T+3 rd_ready
        exp_mem.push_back(mop(1'b0, 16'h0020, 32'h1234_5678));
        exp_rd.push_back(32'h1234_5678);
        do_read(16'h0020);
        drain("rd1_drain");
        check("rd1_strobe_lat", 64'(rd_mem_cyc - rd_issue_cyc), 64'd2);
        check("rd1_ready_lat", 64'(rd_ready_cyc - rd_issue_cyc), 64'd3);

        // FIFO overflow with memory stalled
        mem_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_mem.push_back(mop(1'b1, 16'h0040 + 16'(k), 32'hA000_0000 + k));
            do_write(16'h0040 + 16'(k), 32'hA000_0000 + k);
        end
        #1 check("full_ready", 64'(wr_ready), 64'd0);
        do_write(16'h0044, 32'hA000_0004);
        #1 check("ovf_err", 64'(err_flags), 64'b01);
        mem_stall = 1'b0;
        drain("ovf_drain");
        check("ovf_ready_after", 64'(wr_ready), 64'd1);

        // Read overrun: second request while first is outstanding
        mem_stall = 1'b1;
        exp_mem.push_back(mop(1'b0, 16'h0030, 32'h3030_3030));
        exp_rd.push_back(32'h3030_3030);
        do_read(16'h0030);
        do_read(16'h0031);
        #1 check("ovr_err", 64'(err_flags), 64'b11);
        mem_stall = 1'b0;
        drain("ovr_drain");

        // RAW: queued write to 0x50 must reach memory before the read of 0x50
        mem_stall = 1'b1;
        exp_mem.push_back(mop(1'b1, 16'h0058, 32'h5858_5858));
        exp_mem.push_back(mop(1'b1, 16'h0050, 32'h5050_AAAA));
        exp_mem.push_back(mop(1'b0, 16'h0050, 32'h5050_AAAA));
        exp_rd.push_back(32'h5050_AAAA);
        do_write(16'h0058, 32'h5858_5858);
        do_write(16'h0050, 32'h5050_AAAA);
        do_read(16'h0050);
        mem_stall = 1'b0;
        drain("raw_drain");

        // Starvation bound: reads back-to-back while one write waits
        base_rd = n_rd_done;
        @(negedge tlp_clk);
        exp_mem.push_back(mop(1'b0, 16'h0100, 32'h0000_0100));
        exp_rd.push_back(32'h0000_0100);
        wr_req = 1'b1; wr_addr = 16'h0060; wr_data = 32'h6060_6060;
        rd_req = 1'b1; rd_addr = 16'h0100;
        @(negedge tlp_clk);
        wr_req = 1'b0; rd_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge tlp_clk);
                #1 got = mem_ready && mem_rd_req;
            end
            check("starve_rd_done", 64'(got), 64'd1);
            if (k == 4) exp_mem.push_back(mop(1'b1, 16'h0060, 32'h6060_6060));
            exp_mem.push_back(mop(1'b0, 16'h0100 + 16'(k), 32'h0000_0100 + k));
            exp_rd.push_back(32'h0000_0100 + k);
            rd_req = 1'b1; rd_addr = 16'h0100 + 16'(k);
            @(negedge tlp_clk);
            rd_req = 1'b0;
        end
        drain("starve_drain");
        check("starve_reads_before_wr", 64'(rd_at_last_wr - base_rd), 64'd4);

        // Register window: CTRL read goes to memory, STAT write is discarded
        exp_mem.push_back(mop(1'b0, 16'hFFF0, 32'h0BAD_F00D));
        exp_rd.push_back(32'h0BAD_F00D);
        do_read(16'hFFF0);
        do_write(16'hFFF4, 32'h0000_0001);
        drain("regwin_drain");
        check("regwin_no_start", 64'(n_gpu_start), 64'd0);

        // GPU start / status sequencing
        do_write(16'hFFF0, 32'h0000_0001);
        repeat (3) @(negedge tlp_clk);
        check("start_count1", 64'(n_gpu_start), 64'd1);
        check("busy_set", 64'(gpu_busy), 64'd1);
        exp_rd.push_back(32'h0000_0001);
        do_read(16'hFFF4);
        drain("stat_busy_drain");
        do_write(16'hFFF0, 32'h0000_0001);
        repeat (3) @(negedge tlp_clk);
        check("start_ignored_busy", 64'(n_gpu_start), 64'd1);
        gpu_done = 1'b1;
        repeat (5) @(negedge tlp_clk);
        check("busy_cleared", 64'(gpu_busy), 64'd0);
        exp_rd.push_back(32'h0000_0002);
        do_read(16'hFFF4);
        drain("stat_done_drain");
        gpu_done = 1'b0;
        do_write(16'hFFF0, 32'h0000_0003);
        repeat (3) @(negedge tlp_clk);
        check("start_count2", 64'(n_gpu_start), 64'd2);
        exp_rd.push_back(32'h0000_0001);
        do_read(16'hFFF4);
        drain("stat_restart_drain");

        // Asynchronous reset mid-transaction
        mem_stall = 1'b1;
        do_write(16'h0070, 32'h7070_7070);
        @(negedge tlp_clk);
        #1 check("pre_rst_strobe", 64'(mem_wr_req), 64'd1);
        #2 w_rst_n = 1'b0;
        #1 check("async_rst", 64'({mem_wr_req, mem_rd_req, gpu_busy, err_flags, wr_ready}), 64'b00_0001);
        @(negedge tlp_clk);
        w_rst_n = 1'b1;
        mem_stall = 1'b0;
        repeat (8) @(negedge tlp_clk);
        check("post_rst_idle", 64'({mem_wr_req, mem_rd_req}), 64'd0);
        check("final_queues", 64'(exp_mem.size() + exp_rd.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
